// File: rtl/jk_counter_sequencer.sv
// jk_counter_sequencer: sequences an external JK flip-flop bank through clear/load/count commands,
// generating per-bit J/K drive from its own state and the bank's q feedback.
module jk_counter_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             abort,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             tc
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state, state_n;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] data_r, steps_r, t_up, t_dn;
    logic             accept;

    assign accept = cmd_valid && cmd_ready;

    // Toggle enables: a bit flips when every lower bit is at its wrap value.
    assign t_up[0] = 1'b1;
    assign t_dn[0] = 1'b1;
    for (genvar g = 1; g < WIDTH; g++) begin : g_toggle
        assign t_up[g] = &q_fb[g-1:0];
        assign t_dn[g] = ~|q_fb[g-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            op_r    <= 2'b00;
            data_r  <= '0;
            steps_r <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_r    <= cmd_op;
                data_r  <= cmd_data;
                steps_r <= cmd_data;
            end else if (state == EXEC) begin
                steps_r <= steps_r - 1'b1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        j         = '0;
        k         = '0;
        tc        = 1'b0;
        cmd_ready = reset && state == IDLE;
        busy      = reset && state != IDLE;
        done      = reset && state == DONE;
        case (state)
            IDLE: if (accept) state_n = (cmd_op[1] && cmd_data == '0) ? DONE : EXEC;
            EXEC: begin
                if (!op_r[1]) begin
                    j       = op_r[0] ? data_r : '0;
                    k       = op_r[0] ? ~data_r : '1;
                    state_n = DONE;
                end else begin
                    state_n = (abort || steps_r == WIDTH'(1)) ? DONE : EXEC;
                    if (!abort) begin
                        j  = op_r[0] ? t_dn : t_up;
                        k  = op_r[0] ? t_dn : t_up;
                        tc = op_r[0] ? ~|q_fb : &q_fb;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Reset freezes the bank even mid-count.
        if (!reset) begin
            j  = '0;
            k  = '0;
            tc = 1'b0;
        end
    end
endmodule

// File: tb/tb_jk_counter_sequencer.sv
// tb_jk_counter_sequencer: drives the sequencer against a behavioural JK bank; expected results are
// queued per command and popped by an independent monitor on each done pulse.
module tb_jk_counter_sequencer;
    logic       clk = 1'b0;
    logic       reset, cmd_valid, abort, cmd_ready, busy, done, tc;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data, q, j, k, preset_val;
    logic       preset_en = 1'b0;
    int         errors = 0;
    int         checks = 0;

    typedef struct {
        logic [3:0]  q;
        logic [15:0] tc_mask;
        int          cycles;
    } exp_t;

    exp_t sb[$];

    jk_counter_sequencer #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .abort(abort), .q_fb(q),
        .j(j), .k(k), .busy(busy), .done(done), .tc(tc)
    );

    always #5 clk = ~clk;

    // Bank of JK flip-flops on the same clock; preset lets the bench seed a start value.
    always @(posedge clk) q <= preset_en ? preset_val : ((j & ~q) | (~k & q));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preset(input logic [3:0] v);
        preset_en  = 1'b1;
        preset_val = v;
        tick();
        preset_en  = 1'b0;
    endtask

    // Issue one command; j1/k1 are the expected drives in EXEC cycle 1 when chk is set.
    task automatic run(input logic [1:0] op, input logic [3:0] data, input logic [3:0] eq,
                       input logic [15:0] em, input int ec, input int abort_at,
                       input bit chk, input logic [3:0] j1, input logic [3:0] k1);
        exp_t e;
        int   n;
        e.q = eq;
        e.tc_mask = em;
        e.cycles = ec;
        sb.push_back(e);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            n++;
            abort = (n == abort_at);
            @(negedge clk);
            if (chk && n == 1) begin
                check("exec1_j", j, j1);
                check("exec1_k", k, k1);
            end
            tick();
        end
        abort = 1'b0;
        if (!done) check("done_timeout", done, 1);
        @(negedge clk);
        check("done_j", j, 0);
        check("done_k", k, 0);
        tick();
        @(negedge clk);
        check("ready_after_done", cmd_ready, 1);
    endtask

    // Monitor: counts EXEC cycles and tc pulses, scores each completion against the queue.
    initial begin
        int         idx = 0;
        logic [15:0] mask = '0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                idx  = 0;
                mask = '0;
            end else if (done) begin
                if (sb.size() == 0) check("unexpected_done", done, 0);
                else begin
                    e = sb.pop_front();
                    check("final_q", q, e.q);
                    check("tc_mask", mask, e.tc_mask);
                    check("exec_cycles", idx, e.cycles);
                end
                idx  = 0;
                mask = '0;
            end else if (busy) begin
                if (tc && idx < 16) mask[idx] = 1'b1;
                idx++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_data  = 4'd5;
        abort     = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_j", j, 0);
            check("rst_k", k, 0);
            check("rst_ready", cmd_ready, 0);
            check("rst_done", done, 0);
        end
        tick();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_busy", busy, 0);

        preset(4'b1011);
        run(2'b00, 4'b0000, 4'b0000, 16'h0000, 1, 0, 1, 4'b0000, 4'b1111);
        run(2'b01, 4'b1010, 4'b1010, 16'h0000, 1, 0, 1, 4'b1010, 4'b0101);
        preset(4'b1101);
        run(2'b10, 4'd3, 4'b0000, 16'h0004, 3, 0, 1, 4'b0011, 4'b0011);
        preset(4'b0001);
        run(2'b11, 4'd2, 4'b1111, 16'h0002, 2, 0, 1, 4'b0001, 4'b0001);
        preset(4'b0110);
        run(2'b10, 4'd0, 4'b0110, 16'h0000, 0, 0, 0, 4'b0000, 4'b0000);
        preset(4'b0000);
        run(2'b10, 4'd10, 4'b0100, 16'h0000, 5, 5, 1, 4'b0001, 4'b0001);

        // Reset during cycle 5 of a 10-step count: four steps land, then the bank freezes.
        preset(4'b0000);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_data  = 4'd10;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_j", j, 0);
        check("midrst_k", k, 0);
        check("midrst_busy", busy, 0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("midrst_q", q, 4'b0100);
        check("midrst_ready", cmd_ready, 1);
        check("midrst_done", done, 0);
        tick();
        @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jk_counter_sequencer.md
# jk_counter_sequencer

Controller that sequences an external bank of WIDTH JK flip-flops as a synchronous counter/register. It takes one command at a time over a valid/ready handshake: clear, parallel load, count N steps up, or count N steps down. From its state and the bank's q feedback it generates per-bit J/K drive, and it reports completion and wrap events. It sits between the system command source and the MUX-based JK counter datapath, which it drives directly on the same clock.

## Interface
- WIDTH, 4, number of JK flip-flops in the bank and width of data/step fields (≥2)
- clk  in  1  rising-edge clock shared with the JK bank
- reset  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command (IDLE only)
- cmd_op  in  2  00 clear, 01 load, 10 count up, 11 count down
- cmd_data  in  WIDTH  load value (op 01) or step count N (ops 10/11); ignored for clear
- abort  in  1  terminate a count in progress
- q_fb  in  WIDTH  q outputs of the JK bank
- j  out  WIDTH  J drive to bank
- k  out  WIDTH  K drive to bank
- busy  out  1  high in EXEC and DONE
- done  out  1  one-cycle completion pulse
- tc  out  1  wrap pulse, aligned with the edge on which the bank wraps

## Operation
- FSM states: IDLE, EXEC, DONE. Registers: state, op_r (2b), data_r (WIDTH), steps_r (WIDTH).
- IDLE: cmd_ready=1, j=k=0 (bank holds). On cmd_valid&&cmd_ready, capture op and data. Next state is DONE if op is count and N=0; otherwise EXEC.
- EXEC j/k are combinational functions of op_r, data_r and q_fb:
  - clear: j=0, k=all ones. One cycle.
  - load: j=data_r, k=~data_r. One cycle.
  - count up: bit 0 j=k=1; bit i j=k=&q_fb[i-1:0]. Runs steps_r cycles.
  - count down: bit 0 j=k=1; bit i j=k=~|q_fb[i-1:0]. Runs steps_r cycles.
- steps_r is loaded with N at accept and decremented every EXEC cycle. EXEC→DONE on the edge ending the cycle with steps_r==1, or at the end of a one-cycle clear/load.
- Arithmetic is modulo 2^WIDTH; N ranges 0..2^WIDTH-1.
- tc (combinational, EXEC count only): up with q_fb all ones, or down with q_fb all zeros.
- abort sampled high in EXEC during a count: j=k=0 in that same cycle (no step applied), EXEC→DONE at that edge. abort is ignored for clear/load and outside EXEC.
- DONE: j=k=0, done=1, cmd_ready=0; DONE→IDLE unconditionally.
- cmd_valid outside IDLE is ignored (not queued).

## Timing
- Reset (reset=0 at a rising edge): state=IDLE, steps_r=0, op_r=00, data_r=0. While reset is low, outputs are forced j=k=0, cmd_ready=0, busy=0, done=0, tc=0, regardless of state. This includes reset asserted mid-EXEC: no further steps are applied. The bank's contents are not cleared by this block.
- Accept at edge T0. EXEC runs cycles 1..M with M=1 for clear/load and M=N for counts. The bank updates at the edge ending each EXEC cycle. DONE is cycle M+1; q_fb already reflects the final value when done=1. IDLE with cmd_ready=1 is cycle M+2.
- N=0: DONE in cycle 1, bank untouched.
- Minimum command spacing: 3 cycles (clear/load/N=1).
- q_fb must be stable within the cycle (bank on same clk, no extra pipeline). j/k have a combinational path from q_fb.

## Test plan
- Reset: reset low 2 cycles with cmd_valid=1, cmd_op=10 -> j=k=0, cmd_ready=0, done=0; first cycle after release cmd_ready=1, busy=0.
- Clear then load 4'b1010 (WIDTH=4): clear accepted -> k=1111 one cycle, done at cycle 2 with q_fb=0000; load -> j=1010, k=0101, done with q_fb=1010.
- Count up N=3 from 1101: q_fb 1101→1110→1111→0000; tc=1 only in third EXEC cycle; done next cycle with q_fb=0000; cmd_ready back 1 cycle later.
- Count down N=2 from 0001: q_fb 0000 then 1111; tc=1 in second EXEC cycle only; done with q_fb=1111.
- N=0 up from 0110: DONE in cycle 1, j=k=0 throughout, q_fb stays 0110, tc never asserts.
- Abort/reset mid-run: up N=10 from 0000 with abort in EXEC cycle 5 -> q_fb=0100, done next cycle. Repeat with reset low in cycle 5 -> j=k=0 that cycle, q_fb=0100, no done, IDLE after release.
